// File: rtl/spike_generator_array_if.sv
// ---------------------------------------------------------------------------
// spike_generator_array_if
//   TagCtChannel: a valid/ack channel that carries one (tag, ct) pair per
//   acknowledged transfer.
//
//   tag [Ntag] : source -> sink, item tag (generator index)
//   ct  [Nct]  : source -> sink, spike count for that tag
//   v          : source -> sink, item valid; held until acknowledged
//   a          : sink -> source, acknowledge, sampled at posedge while v=1
// ---------------------------------------------------------------------------
interface spike_generator_array_if #(
    parameter int Ntag = 10,
    parameter int Nct  = 10
);
    logic [Ntag-1:0] tag;
    logic [Nct-1:0]  ct;
    logic            v;
    logic            a;

    modport master (output tag, output ct, output v, input a);
    modport slave  (input tag, input ct, input v, output a);
endinterface

// File: rtl/spike_generator_array.sv
// ---------------------------------------------------------------------------
// spike_generator_array
//   Array of Ngens fixed-rate spike generators. Each update_pulse sweeps the
//   first gens_used generators; each adds its Nct.Nfrac rate to a fractional
//   accumulator and, when the integer part of the sum is non-zero, emits
//   (tag = generator index, ct = integer part, saturated) on the TagCtChannel.
//
//   clk          : clock
//   reset        : asynchronous active-low reset
//   out          : TagCtChannel source (tag, ct, v out; a in)
//   update_pulse : one-cycle strobe that starts a sweep
//   gens_used    : number of generators swept, clamped to Ngens
//   cfg_wr       : config write strobe
//   cfg_idx      : generator index to configure
//   cfg_rate     : new rate (unsigned Nct.Nfrac); 0 disables the generator
//   overrun      : sticky flag, an update_pulse arrived while a sweep ran
// ---------------------------------------------------------------------------
module spike_generator_array #(
    parameter int Ngens = 16,
    parameter int Ntag  = 10,
    parameter int Nct   = 10,
    parameter int Nfrac = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    spike_generator_array_if.master      out,
    input  logic                         update_pulse,
    input  logic [$clog2(Ngens+1)-1:0]   gens_used,
    input  logic                         cfg_wr,
    input  logic [$clog2(Ngens)-1:0]     cfg_idx,
    input  logic [Nct+Nfrac-1:0]         cfg_rate,
    output logic                         overrun
);

    localparam int GW = $clog2(Ngens + 1);
    localparam int IW = $clog2(Ngens);
    localparam int RW = Nct + Nfrac;

    typedef enum logic [1:0] {IDLE, SCAN, SEND} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [Ntag-1:0]   tag_q, tag_d;
    logic [Nct-1:0]    ct_q, ct_d;
    logic              overrun_q, overrun_d;

    logic [RW-1:0]     rate_q [Ngens];
    logic [Nfrac-1:0]  acc_q  [Ngens];

    logic [GW-1:0]     gens_eff;
    logic              last;
    logic [RW:0]       sum;
    logic [Nct:0]      ct_raw;
    logic [Nct-1:0]    ct_new;

    // Requests above Ngens sweep the whole array.
    assign gens_eff = (gens_used > GW'(Ngens)) ? GW'(Ngens) : gens_used;
    assign last     = (GW'(idx_q) == gens_eff - GW'(1));

    // One extra bit catches the carry; a set top bit means the count
    // overflowed Nct bits and is clamped rather than wrapped.
    assign sum    = (RW+1)'(acc_q[idx_q]) + (RW+1)'(rate_q[idx_q]);
    assign ct_raw = sum[RW:Nfrac];
    assign ct_new = ct_raw[Nct] ? '1 : ct_raw[Nct-1:0];

    // State and emission registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tag_q     <= '0;
            ct_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            ct_q      <= ct_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        ct_d      = ct_q;
        overrun_d = overrun_q | (update_pulse && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (update_pulse && (gens_eff != '0)) begin
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ct_new != '0) begin
                    tag_d   = Ntag'(idx_q);
                    ct_d    = ct_new;
                    state_d = SEND;
                end else if (last) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SEND: begin
                if (out.a) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: v is a pure decode of the state register, so reset drops it
    // asynchronously and it falls the cycle after an ack.
    assign out.v   = (state_q == SEND);
    assign out.tag = tag_q;
    assign out.ct  = ct_q;
    assign overrun = overrun_q;

    // Generator register array.
    // NOTE: this array is built from flops, not RAM, so it is cleared by the
    // reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Ngens; i++) begin
                rate_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            if (state_q == SCAN) begin
                acc_q[idx_q] <= sum[Nfrac-1:0];
            end
            // Placed after the SCAN update so a same-index config write wins.
            if (cfg_wr && (int'(cfg_idx) < Ngens)) begin
                rate_q[cfg_idx] <= cfg_rate;
                acc_q[cfg_idx]  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spike_generator_array.sv
// ---------------------------------------------------------------------------
// tb_spike_generator_array
//   Directed bench for spike_generator_array. A negedge monitor records every
//   acknowledged (tag, ct) pair into a queue; an ack driver answers v after a
//   programmable number of cycles, or can be disabled for manual acks.
// ---------------------------------------------------------------------------
module tb_spike_generator_array;

    localparam int Ngens = 16;
    localparam int Ntag  = 10;
    localparam int Nct   = 10;
    localparam int Nfrac = 8;

    logic        clk;
    logic        reset;
    logic        update_pulse;
    logic [4:0]  gens_used;
    logic        cfg_wr;
    logic [3:0]  cfg_idx;
    logic [17:0] cfg_rate;
    logic        overrun;

    spike_generator_array_if #(.Ntag(Ntag), .Nct(Nct)) bus ();

    spike_generator_array #(
        .Ngens (Ngens),
        .Ntag  (Ntag),
        .Nct   (Nct),
        .Nfrac (Nfrac)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .out          (bus),
        .update_pulse (update_pulse),
        .gens_used    (gens_used),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_rate     (cfg_rate),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Emission log: {tag, ct} of every acknowledged item.
    logic [19:0] emits [$];

    always @(negedge clk) begin
        if (reset && bus.v && bus.a) emits.push_back({bus.tag, bus.ct});
    end

    // Ack driver: after v has been seen for ack_delay extra cycles, raise a
    // for one cycle.
    bit ack_en    = 1'b1;
    int ack_delay = 0;

    initial begin
        int cnt;
        cnt   = 0;
        bus.a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_en) begin
                if (bus.a) begin
                    bus.a = 1'b0;
                    cnt   = 0;
                end else if (bus.v) begin
                    if (cnt >= ack_delay) bus.a = 1'b1;
                    else cnt++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        update_pulse = 1'b1;
        cyc(1);
        update_pulse = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] idx, input logic [17:0] rate);
        cfg_wr   = 1'b1;
        cfg_idx  = idx;
        cfg_rate = rate;
        cyc(1);
        cfg_wr   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.a = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        emits.delete();
    endtask

    task automatic wait_v(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.v && n < budget) begin
            cyc(1);
            n++;
        end
        check(name, 32'(bus.v), 32'd1);
    endtask

    task automatic expect_emit(input string name, input int tag, input int ct);
        check({name, "_avail"}, 32'(emits.size() != 0), 32'd1);
        if (emits.size() != 0) begin
            check(name, 32'(emits.pop_front()), 32'({tag[9:0], ct[9:0]}));
        end
    endtask

    initial begin
        int bad;
        reset        = 1'b0;
        update_pulse = 1'b0;
        gens_used    = '0;
        cfg_wr       = 1'b0;
        cfg_idx      = '0;
        cfg_rate     = '0;
        cyc(2);

        // Reset state.
        check("rst_v",       32'(bus.v),   32'd0);
        check("rst_tag",     32'(bus.tag), 32'd0);
        check("rst_ct",      32'(bus.ct),  32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        cyc(1);

        // Rate 0.5: emits on every second pulse.
        cfg(4'd0, 18'h00080);
        gens_used = 5'd1;
        ack_delay = 0;
        pulse(); cyc(10);
        check("half_p1_cnt", 32'(emits.size()), 32'd0);
        pulse(); cyc(10);
        expect_emit("half_p2", 0, 1);
        pulse(); cyc(10);
        check("half_p3_cnt", 32'(emits.size()), 32'd0);
        pulse(); cyc(10);
        expect_emit("half_p4", 0, 1);
        // acc is back to 0: the next pulse is silent, the one after emits.
        pulse(); cyc(10);
        check("half_p5_cnt", 32'(emits.size()), 32'd0);
        pulse(); cyc(10);
        expect_emit("half_p6", 0, 1);

        // Multi-count and latency: v rises 5 edges after the pulse edge.
        do_reset();
        cfg(4'd3, 18'h00300);
        gens_used    = 5'd4;
        update_pulse = 1'b1;
        cyc(1);
        update_pulse = 1'b0;
        cyc(3);
        check("lat_v_early", 32'(bus.v), 32'd0);
        cyc(1);
        check("lat_v_edge5", 32'(bus.v),   32'd1);
        check("lat_tag",     32'(bus.tag), 32'd3);
        check("lat_ct",      32'(bus.ct),  32'd3);
        cyc(10);
        expect_emit("multi", 3, 3);
        check("multi_cnt", 32'(emits.size()), 32'd0);

        // Saturation: integer part 1023 and then 1024 both clamp to 1023.
        do_reset();
        cfg(4'd0, 18'h3FFFF);
        gens_used = 5'd1;
        pulse(); cyc(10);
        expect_emit("sat_p1", 0, 1023);
        pulse(); cyc(10);
        expect_emit("sat_p2", 0, 1023);

        // Back-pressure with manual ack.
        do_reset();
        cfg(4'd0, 18'h00100);
        cfg(4'd1, 18'h00100);
        gens_used = 5'd2;
        ack_en    = 1'b0;
        pulse();
        wait_v("bp_wait_v", 10);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.v !== 1'b1 || bus.tag !== 10'd0 || bus.ct !== 10'd1) bad++;
        end
        check("bp_hold_bad_cycles", 32'(bad), 32'd0);
        bus.a = 1'b1;
        cyc(1);
        bus.a = 1'b0;
        check("bp_gap_v", 32'(bus.v), 32'd0);
        cyc(1);
        check("bp_next_v",   32'(bus.v),   32'd1);
        check("bp_next_tag", 32'(bus.tag), 32'd1);
        check("bp_next_ct",  32'(bus.ct),  32'd1);
        bus.a = 1'b1;
        cyc(1);
        bus.a = 1'b0;
        cyc(5);
        expect_emit("bp_e0", 0, 1);
        expect_emit("bp_e1", 1, 1);
        ack_en = 1'b1;

        // Overrun: second pulse mid-sweep is dropped.
        do_reset();
        for (int i = 0; i < 16; i++) cfg(4'(i), 18'h00100);
        gens_used = 5'd16;
        ack_delay = 10;
        pulse();
        cyc(30);
        check("ovr_before", 32'(overrun), 32'd0);
        pulse();
        check("ovr_set", 32'(overrun), 32'd1);
        cyc(400);
        check("ovr_cnt", 32'(emits.size()), 32'd16);
        for (int i = 0; i < 16; i++) expect_emit("ovr_item", i, 1);
        check("ovr_sticky", 32'(overrun), 32'd1);
        ack_delay = 0;

        // gens_used = 0 sweeps nothing; oversized gens_used clamps to 16.
        do_reset();
        cfg(4'd0,  18'h00100);
        cfg(4'd15, 18'h00100);
        gens_used = 5'd0;
        pulse(); cyc(20);
        check("g0_cnt",     32'(emits.size()), 32'd0);
        check("g0_overrun", 32'(overrun),      32'd0);
        gens_used = 5'd31;
        pulse(); cyc(40);
        expect_emit("clamp_e0",  0,  1);
        expect_emit("clamp_e15", 15, 1);
        check("clamp_cnt", 32'(emits.size()), 32'd0);

        // Config collision: write to idx 2 on the edge that scans idx 2.
        do_reset();
        cfg(4'd2, 18'h000C0);
        gens_used    = 5'd3;
        update_pulse = 1'b1;
        cyc(1);
        update_pulse = 1'b0;
        cyc(2);
        cfg(4'd2, 18'h00040);
        cyc(10);
        check("col_sweep0_cnt", 32'(emits.size()), 32'd0);
        for (int p = 0; p < 3; p++) begin
            pulse(); cyc(10);
        end
        check("col_p3_cnt", 32'(emits.size()), 32'd0);
        pulse(); cyc(10);
        expect_emit("col_p4", 2, 1);

        // Reset mid-SEND.
        do_reset();
        cfg(4'd0, 18'h00100);
        gens_used = 5'd1;
        ack_en    = 1'b0;
        pulse();
        wait_v("rs_wait_v", 10);
        pulse();
        check("rs_overrun_pre", 32'(overrun), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rs_async_v", 32'(bus.v), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        ack_en = 1'b1;
        check("rs_overrun", 32'(overrun), 32'd0);
        check("rs_tag",     32'(bus.tag), 32'd0);
        check("rs_ct",      32'(bus.ct),  32'd0);
        emits.delete();
        pulse(); cyc(20);
        check("rs_post_cnt",     32'(emits.size()), 32'd0);
        check("rs_post_overrun", 32'(overrun),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
